// File: rtl/nrdiv_pkg.sv
// Shared definitions for the parametrised non-restoring divider.
// Holds the controller state encoding and the partial-remainder width helper.
package nrdiv_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam logic [STATE_W-1:0] IDLE = ST_IDLE;
  localparam logic [STATE_W-1:0] ITER = ST_ITER;
  localparam logic [STATE_W-1:0] FIX  = ST_FIX;

  // The partial remainder carries one extra bit so its sign survives each add/sub step.
  function automatic int step_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/nrdiv_if.sv
// Request/acknowledge bus between a divider client (master) and the divider (slave).
interface nrdiv_if #(
  parameter int WIDTH = 8
) ();

  logic             req;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             ack;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output req, dividend, divisor,
    input  busy, ack, quotient, remainder, div_by_zero
  );

  modport slave (
    input  req, dividend, divisor,
    output busy, ack, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/nrdiv_step.sv
// One combinational non-restoring division step.
// Shifts the next dividend bit into the partial remainder, adds or subtracts the
// divisor depending on the sign the remainder had before the shift, and shifts
// the resulting quotient bit into A.
import nrdiv_pkg::*;

module nrdiv_step #(
  parameter int WIDTH = 8
) (
  input  logic [step_width(WIDTH)-1:0] p_in,
  input  logic [WIDTH-1:0]             a_in,
  input  logic [WIDTH-1:0]             b,
  output logic [step_width(WIDTH)-1:0] p_out,
  output logic [WIDTH-1:0]             a_out
);

  localparam int PW = step_width(WIDTH);

  logic [PW-1:0] p_shift;
  logic [PW-1:0] b_ext;

  // Add back when the remainder went negative, otherwise keep subtracting.
  always_comb begin
    p_shift = {p_in[WIDTH-1:0], a_in[WIDTH-1]};
    b_ext   = {1'b0, b};
    p_out   = p_in[WIDTH] ? (p_shift + b_ext) : (p_shift - b_ext);
    a_out   = {a_in[WIDTH-2:0], ~p_out[WIDTH]};
  end

endmodule

// File: rtl/nrdiv_param.sv
// Parametrised non-restoring integer divider behind a req/ack slave port.
// UNROLL steps are chained per clock; a zero divisor skips straight to the result.
// Optional feature macro: NRDIV_SIGNED_EN selects two's complement operands
// (truncating division); without it the divider is purely unsigned.
import nrdiv_pkg::*;

module nrdiv_param #(
  parameter int WIDTH  = 8,
  parameter int UNROLL = 1
) (
  input logic   clk,
  input logic   reset_n,
  nrdiv_if.slave bus
);

  localparam int PW = step_width(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || UNROLL < 1 || (WIDTH % UNROLL) != 0) begin : g_bad_cfg
    $error("nrdiv_param: WIDTH must be >= 2 and a multiple of UNROLL");
  end

  logic [STATE_W-1:0] state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [PW-1:0]      p_reg;
  logic [CW-1:0]      count;
  logic               dbz;
  logic               busy_r;
  logic               ack_r;
  logic [WIDTH-1:0]   quotient_r;
  logic [WIDTH-1:0]   remainder_r;
  logic               div_by_zero_r;

  logic [WIDTH-1:0]   a_start;
  logic [WIDTH-1:0]   b_start;
  logic [CW-1:0]      count_nxt;
  logic [PW-1:0]      p_fix;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [PW-1:0]      p_last;
  logic [WIDTH-1:0]   a_last;

  // Chain of UNROLL single-step stages fed from the working registers.
  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    logic [PW-1:0]    p_i;
    logic [WIDTH-1:0] a_i;
    logic [PW-1:0]    p_o;
    logic [WIDTH-1:0] a_o;
    if (i == 0) begin : g_first
      assign p_i = p_reg;
      assign a_i = a_reg;
    end else begin : g_next
      assign p_i = g_step[i-1].p_o;
      assign a_i = g_step[i-1].a_o;
    end
    nrdiv_step #(.WIDTH(WIDTH)) u_step (
      .p_in  (p_i),
      .a_in  (a_i),
      .b     (b_reg),
      .p_out (p_o),
      .a_out (a_o)
    );
  end

  assign p_last    = g_step[UNROLL-1].p_o;
  assign a_last    = g_step[UNROLL-1].a_o;
  assign count_nxt = count + CW'(UNROLL);

  // A negative final remainder still owes one divisor add-back.
  always_comb begin
    p_fix   = p_reg + {1'b0, b_reg};
    rem_mag = p_reg[WIDTH] ? p_fix[WIDTH-1:0] : p_reg[WIDTH-1:0];
  end

`ifdef NRDIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Core runs on magnitudes; a zero divisor keeps the raw dividend for the remainder.
  always_comb begin
    a_start = (bus.dividend[WIDTH-1] && (bus.divisor != '0)) ? -bus.dividend : bus.dividend;
    b_start = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
  end

  // Remember the operand signs at accept so FIX can restore them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && bus.req) begin
      neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_r <= bus.dividend[WIDTH-1];
    end
  end

  // Quotient negates on differing signs, remainder follows the dividend sign.
  always_comb begin
    q_fix = neg_q ? -a_reg : a_reg;
    r_fix = neg_r ? -rem_mag : rem_mag;
    if (dbz) begin
      q_fix = '1;
      r_fix = a_reg;
    end
  end
`else
  // Unsigned operands go straight into the core.
  always_comb begin
    a_start = bus.dividend;
    b_start = bus.divisor;
  end

  // Final result selection, with the fixed divide-by-zero answer.
  always_comb begin
    q_fix = a_reg;
    r_fix = rem_mag;
    if (dbz) begin
      q_fix = '1;
      r_fix = a_reg;
    end
  end
`endif

  // Controller: accept in IDLE, iterate, then publish the result with a one-cycle ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      p_reg         <= '0;
      count         <= '0;
      dbz           <= 1'b0;
      busy_r        <= 1'b0;
      ack_r         <= 1'b0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      div_by_zero_r <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            a_reg  <= a_start;
            b_reg  <= b_start;
            p_reg  <= '0;
            count  <= '0;
            busy_r <= 1'b1;
            dbz    <= (bus.divisor == '0);
            state  <= (bus.divisor == '0) ? FIX : ITER;
          end
        end
        ITER: begin
          p_reg <= p_last;
          a_reg <= a_last;
          count <= count_nxt;
          if (count_nxt == CW'(WIDTH)) state <= FIX;
        end
        FIX: begin
          quotient_r    <= q_fix;
          remainder_r   <= r_fix;
          div_by_zero_r <= dbz;
          ack_r         <= 1'b1;
          busy_r        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.ack         = ack_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = div_by_zero_r;

endmodule
